// File: rtl/uart_fetch_arbiter.sv
// Two-requester round-robin arbiter over a single UART word-fetch link.
// Sends the granted address on TX, waits for the reply word on RX, retries on timeout.
//
// Ports:
//   clk, reset          - clock, async active-high reset
//   reqN_valid/addr     - fetch request from requester N (0 = ifetch, 1 = debug)
//   reqN_grant          - 1-cycle accept pulse to requester N
//   rspN_valid          - 1-cycle response pulse to requester N
//   rsp_data, rsp_err   - response word and retries-exhausted flag
//   query_start/addr    - TX launch pulse and address to send
//   tx_busy             - TX shifter busy
//   rx_word_valid/word  - received reply word
//   busy                - transaction in flight
module uart_fetch_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_W          = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  output logic        req0_grant,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  output logic        req1_grant,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        query_start,
  output logic [31:0] query_addr,
  input  logic        tx_busy,
  input  logic        rx_word_valid,
  input  logic [31:0] rx_word,
  output logic        busy
);

  localparam int RW = (MAX_RETRIES < 1) ? 1
                    : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] TC_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_TX,
    WAIT_RX,
    RESPOND
  } state_t;

  state_t          state;
  logic            owner;
  logic            last_grant;
  logic [RW-1:0]   retry_cnt;
  logic [CNT_W-1:0] tcnt;
  logic            tx_seen;
  logic            wt_cnt;

  logic pick0;
  logic pick1;

  // On a tie the requester that did not win last time goes first.
  assign pick0 = req0_valid & (~req1_valid | last_grant);
  assign pick1 = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      retry_cnt   <= '0;
      tcnt        <= '0;
      tx_seen     <= 1'b0;
      wt_cnt      <= 1'b0;
      req0_grant  <= 1'b0;
      req1_grant  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      query_start <= 1'b0;
      query_addr  <= '0;
      busy        <= 1'b0;
    end else begin
      req0_grant  <= 1'b0;
      req1_grant  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      query_start <= 1'b0;

      // Timeout counter runs from the query pulse on and saturates.
      if ((state == WAIT_TX || state == WAIT_RX) &&
          tcnt != CNT_MAX)
        tcnt <= tcnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (pick0 | pick1) begin
            req0_grant <= pick0;
            req1_grant <= pick1;
            owner      <= pick1;
            last_grant <= pick1;
            query_addr <= pick1 ? req1_addr : req0_addr;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_busy) begin
            query_start <= 1'b1;
            tcnt        <= '0;
            tx_seen     <= 1'b0;
            wt_cnt      <= 1'b0;
            state       <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // Leave on busy falling, or after 2 cycles if TX never
          // reported busy at all.
          wt_cnt <= 1'b1;
          if (tx_busy)
            tx_seen <= 1'b1;
          else if (tx_seen || wt_cnt)
            state <= WAIT_RX;
        end
        WAIT_RX: begin
          if (rx_word_valid) begin
            rsp_data <= rx_word;
            rsp_err  <= 1'b0;
            state    <= RESPOND;
          end else if (tcnt >= TC_LAST) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ISSUE;
            end else begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              state    <= RESPOND;
            end
          end
        end
        RESPOND: begin
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          retry_cnt  <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fetch_arbiter.sv
// Scoreboard bench for uart_fetch_arbiter.
// Directed requests, a scripted UART responder, and a monitor that checks grants and responses.
module tb_uart_fetch_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] addr;
  } gexp_t;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          err;
    bit          lat;
  } rexp_t;

  typedef struct {
    bit          reply;
    int          shift;
    int          delay;
    logic [31:0] word;
  } plan_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [31:0] req0_addr;
  logic        req0_grant;
  logic        rsp0_valid;
  logic        req1_valid;
  logic [31:0] req1_addr;
  logic        req1_grant;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        query_start;
  logic [31:0] query_addr;
  logic        tx_busy;
  logic        rx_word_valid;
  logic [31:0] rx_word;
  logic        busy;

  logic bp_hold;
  logic tx_shift;
  assign tx_busy = bp_hold | tx_shift;

  uart_fetch_arbiter #(
    .TIMEOUT_CYCLES(100),
    .MAX_RETRIES   (3),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_addr    (req0_addr),
    .req0_grant   (req0_grant),
    .rsp0_valid   (rsp0_valid),
    .req1_valid   (req1_valid),
    .req1_addr    (req1_addr),
    .req1_grant   (req1_grant),
    .rsp1_valid   (rsp1_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .query_start  (query_start),
    .query_addr   (query_addr),
    .tx_busy      (tx_busy),
    .rx_word_valid(rx_word_valid),
    .rx_word      (rx_word),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_vec = 0;
  int    n_bad = 0;
  int    g_cyc = 0;
  int    rx_cyc = -100;
  int    qs_log[$];
  gexp_t exp_g[$];
  rexp_t exp_r[$];
  plan_t plans[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)",
             nm, cyc);
  endtask

  task automatic eg(input bit id, input logic [31:0] a);
    gexp_t g;
    g.id = id;
    g.addr = a;
    exp_g.push_back(g);
  endtask

  task automatic er(input bit id, input logic [31:0] d,
                    input bit err, input bit lat);
    rexp_t r;
    r.id = id;
    r.data = d;
    r.err = err;
    r.lat = lat;
    exp_r.push_back(r);
  endtask

  task automatic ep(input bit reply, input int shift,
                    input int delay, input logic [31:0] w);
    plan_t p;
    p.reply = reply;
    p.shift = shift;
    p.delay = delay;
    p.word = w;
    plans.push_back(p);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant
  // or a response.
  initial begin
    gexp_t ge;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rx_word_valid) rx_cyc = cyc;
        if (query_start) qs_log.push_back(cyc);
        if (req0_grant || req1_grant) begin
          g_cyc = cyc;
          chk("grant_onehot",
              32'(req0_grant & req1_grant), 32'd0);
          if (exp_g.size() == 0) begin
            bound_fail("grant_unexpected");
          end else begin
            ge = exp_g.pop_front();
            chk("grant_id", 32'(req1_grant), 32'(ge.id));
            chk("grant_addr", query_addr, ge.addr);
          end
        end
        if (rsp0_valid || rsp1_valid) begin
          chk("rsp_onehot",
              32'(rsp0_valid & rsp1_valid), 32'd0);
          if (exp_r.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL rsp_unexpected: got rsp%0d, want none",
                     rsp1_valid);
          end else begin
            re = exp_r.pop_front();
            chk("rsp_id", 32'(rsp1_valid), 32'(re.id));
            chk("rsp_data", rsp_data, re.data);
            chk("rsp_err", 32'(rsp_err), 32'(re.err));
            if (re.lat)
              chk("rsp_lat", 32'(cyc - rx_cyc), 32'd2);
          end
        end
      end
    end
  end

  // UART model: each query pulse consumes one plan entry.
  initial begin
    plan_t p;
    tx_shift = 1'b0;
    rx_word_valid = 1'b0;
    rx_word = '0;
    forever begin
      @(negedge clk);
      if (query_start && !reset) begin
        if (plans.size() > 0) p = plans.pop_front();
        else begin
          p.reply = 1'b0;
          p.shift = 0;
          p.delay = 0;
          p.word = '0;
        end
        for (int i = 1; i <= p.delay; i++) begin
          @(posedge clk);
          #1;
          tx_shift = (i <= p.shift);
          rx_word_valid = p.reply && (i == p.delay);
          rx_word = rx_word_valid ? p.word : '0;
        end
        @(posedge clk);
        #1;
        tx_shift = 1'b0;
        rx_word_valid = 1'b0;
      end
    end
  end

  task automatic request(input bit id, input logic [31:0] a);
    int n = 0;
    bit got = 0;
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_addr = a;
      req0_valid = 1'b1;
    end else begin
      req1_addr = a;
      req1_valid = 1'b1;
    end
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      got = (id == 0) ? req0_grant : req1_grant;
    end
    if (!got) bound_fail("grant_wait");
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_qs(input int target);
    int n = 0;
    while (qs_log.size() < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qs_log.size() < target) bound_fail("qs_wait");
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_r.size() != 0 || exp_g.size() != 0 || busy)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      bound_fail(nm);
      exp_r.delete();
      exp_g.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        32'({req0_grant, req1_grant, rsp0_valid, rsp1_valid,
             rsp_err, query_start, busy}), 32'd0);
    chk({nm, "_data"}, rsp_data, 32'd0);
    chk({nm, "_addr"}, query_addr, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    bp_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single fetch
    eg(0, 32'h40);
    ep(1, 0, 50, 32'hDEADBEEF);
    er(0, 32'hDEADBEEF, 0, 1);
    q0 = qs_log.size();
    request(0, 32'h40);
    wait_qs(q0 + 1);
    if (qs_log.size() > q0)
      chk("qs_lat", 32'(qs_log[q0] - g_cyc), 32'd1);
    chk("qs_addr", query_addr, 32'h40);
    drain("single");

    // Contention, then round-robin on re-request
    do_reset();
    eg(0, 32'h100);
    eg(1, 32'h200);
    ep(1, 3, 20, 32'hA0A00001);
    ep(1, 0, 20, 32'hB0B00002);
    er(0, 32'hA0A00001, 0, 1);
    er(1, 32'hB0B00002, 0, 1);
    fork
      request(0, 32'h100);
      request(1, 32'h200);
    join
    drain("contend");
    eg(0, 32'h104);
    eg(1, 32'h204);
    ep(1, 0, 15, 32'hC0C00003);
    ep(1, 0, 15, 32'hD0D00004);
    er(0, 32'hC0C00003, 0, 1);
    er(1, 32'hD0D00004, 0, 1);
    fork
      request(0, 32'h104);
      request(1, 32'h204);
    join
    drain("contend2");

    // Timeout then recovery
    eg(0, 32'h300);
    ep(0, 0, 0, 32'h0);
    ep(1, 0, 30, 32'h12345678);
    er(0, 32'h12345678, 0, 1);
    q0 = qs_log.size();
    request(0, 32'h300);
    drain("timeout");
    chk("to_pulses", 32'(qs_log.size() - q0), 32'd2);
    if (qs_log.size() >= q0 + 2)
      chk("to_gap", 32'(qs_log[q0+1] - qs_log[q0]), 32'd101);

    // Retries exhausted, then a normal fetch
    eg(1, 32'h400);
    repeat (4) ep(0, 0, 0, 32'h0);
    er(1, 32'h0, 1, 0);
    q0 = qs_log.size();
    request(1, 32'h400);
    drain("exhaust");
    chk("ex_pulses", 32'(qs_log.size() - q0), 32'd4);
    chk("ex_busy", 32'(busy), 32'd0);
    eg(0, 32'h404);
    ep(1, 0, 10, 32'h0BADF00D);
    er(0, 32'h0BADF00D, 0, 1);
    request(0, 32'h404);
    drain("after_ex");

    // TX back-pressure at grant
    bp_hold = 1'b1;
    eg(1, 32'h500);
    ep(1, 5, 20, 32'hCAFEF00D);
    er(1, 32'hCAFEF00D, 0, 1);
    q0 = qs_log.size();
    request(1, 32'h500);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < g_cyc + 30);
    bp_hold = 1'b0;
    drain("backpress");
    chk("bp_pulses", 32'(qs_log.size() - q0), 32'd1);
    if (qs_log.size() > q0)
      chk("bp_lat", 32'(qs_log[q0] - g_cyc), 32'd31);

    // Reply coincides with timeout terminal count
    eg(0, 32'h600);
    ep(1, 0, 99, 32'h600D600D);
    er(0, 32'h600D600D, 0, 1);
    q0 = qs_log.size();
    request(0, 32'h600);
    drain("coincide");
    chk("co_pulses", 32'(qs_log.size() - q0), 32'd1);

    // Reset during WAIT_RX
    eg(0, 32'h700);
    ep(0, 0, 0, 32'h0);
    q0 = qs_log.size();
    request(0, 32'h700);
    wait_qs(q0 + 1);
    repeat (10) @(negedge clk);
    chk("busy_pre_reset", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    plans.delete();
    eg(0, 32'h800);
    eg(1, 32'h900);
    ep(1, 0, 12, 32'h88880000);
    ep(1, 0, 12, 32'h99990000);
    er(0, 32'h88880000, 0, 1);
    er(1, 32'h99990000, 0, 1);
    fork
      request(0, 32'h800);
      request(1, 32'h900);
    join
    drain("post_reset");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
